// File: rtl/writeback_arbiter_pkg.sv
// Shared widths, the register-0 constant and the mult/div result entry type for
// the regfile writeback arbiter.
package writeback_arbiter_pkg;

   localparam int DATA_WIDTH        = 32;
   localparam int REG_ADDR_W        = 5;
   localparam int NUM_REGS          = 1 << REG_ADDR_W;
   localparam int MD_FIFO_DEPTH_DEF = 2;

   typedef logic [REG_ADDR_W-1:0] reg_idx_t;
   typedef logic [DATA_WIDTH-1:0] data_t;

   localparam reg_idx_t REG_ZERO = '0;

   typedef struct packed {
      reg_idx_t idx;
      data_t    data;
   } md_entry_t;

   typedef enum logic [1:0] {
      SRC_NONE,
      SRC_WB,
      SRC_FIFO,
      SRC_BYPASS
   } wr_src_t;

endpackage

// File: rtl/writeback_arbiter_if.sv
// Pipeline / mult-div / decode / regfile signals seen by the writeback arbiter.
// master = the surrounding core, slave = the arbiter.
interface writeback_arbiter_if;
   import writeback_arbiter_pkg::*;

   logic     wb_valid;
   reg_idx_t wb_reg;
   data_t    wb_data;

   logic     md_issue;
   reg_idx_t md_issue_reg;
   logic     md_done;
   reg_idx_t md_done_reg;
   data_t    md_done_data;
   logic     md_ready;

   reg_idx_t ctrl_readRegA;
   reg_idx_t ctrl_readRegB;
   logic     hazard_a;
   logic     hazard_b;
   logic     issue_stall;

   logic     ctrl_writeEnable;
   reg_idx_t ctrl_writeReg;
   data_t    data_writeReg;

   modport master (
      output wb_valid, wb_reg, wb_data,
      output md_issue, md_issue_reg, md_done, md_done_reg, md_done_data,
      output ctrl_readRegA, ctrl_readRegB,
      input  md_ready, hazard_a, hazard_b, issue_stall,
      input  ctrl_writeEnable, ctrl_writeReg, data_writeReg
   );

   modport slave (
      input  wb_valid, wb_reg, wb_data,
      input  md_issue, md_issue_reg, md_done, md_done_reg, md_done_data,
      input  ctrl_readRegA, ctrl_readRegB,
      output md_ready, hazard_a, hazard_b, issue_stall,
      output ctrl_writeEnable, ctrl_writeReg, data_writeReg
   );

endinterface

// File: rtl/writeback_arbiter_fifo.sv
// md_result_fifo: small synchronous FIFO holding mult/div results that lost the
// write port to a pipeline writeback. DEPTH must be a power of two >= 2.
module md_result_fifo
   import writeback_arbiter_pkg::*;
#(
   parameter int DEPTH = MD_FIFO_DEPTH_DEF
) (
   input  logic      clock,
   input  logic      ctrl_reset,
   input  logic      push,
   input  md_entry_t push_entry,
   input  logic      pop,
   output logic      full,
   output logic      empty,
   output md_entry_t head
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   md_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W:0]   count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   // Pointers are exactly log2(DEPTH) bits, so they wrap mod depth for free.
   always_ff @(posedge clock) begin
      if (ctrl_reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= push_entry;
   end

endmodule

// File: rtl/writeback_arbiter.sv
// Drives the regfile write port from MW writebacks (priority) and buffered or
// bypassed mult/div results, and keeps the busy scoreboard used by decode.
module writeback_arbiter
   import writeback_arbiter_pkg::*;
#(
   parameter int MD_FIFO_DEPTH = MD_FIFO_DEPTH_DEF
) (
   input  logic                clock,
   input  logic                ctrl_reset,
   writeback_arbiter_if.slave  bus
);

   wr_src_t              src;
   md_entry_t            md_in;
   md_entry_t            head;
   logic                 full;
   logic                 empty;
   logic                 push;
   logic                 pop;
   logic                 bypass;
   reg_idx_t             wr_reg;
   data_t                wr_data;

   logic [NUM_REGS-1:0]  busy;
   logic [NUM_REGS-1:0]  busy_nxt;
   logic                 md_wr;
   reg_idx_t             md_wr_reg;
   logic                 issue_set;

   assign md_in = '{idx: bus.md_done_reg, data: bus.md_done_data};

   md_result_fifo #(.DEPTH(MD_FIFO_DEPTH)) u_fifo (
      .clock      (clock),
      .ctrl_reset (ctrl_reset),
      .push       (push),
      .push_entry (md_in),
      .pop        (pop),
      .full       (full),
      .empty      (empty),
      .head       (head)
   );

   // MW never stalls; buffered results drain before a fresh one may bypass.
   always_comb begin
      src = SRC_NONE;
      if (bus.wb_valid)     src = SRC_WB;
      else if (!empty)      src = SRC_FIFO;
      else if (bus.md_done) src = SRC_BYPASS;
   end

   assign pop          = (src == SRC_FIFO);
   assign bypass       = (src == SRC_BYPASS);
   assign bus.md_ready = ~full | (~bus.wb_valid & empty);
   assign push         = bus.md_done & bus.md_ready & ~bypass;

   always_comb begin
      wr_reg  = REG_ZERO;
      wr_data = '0;
      case (src)
         SRC_WB: begin
            wr_reg  = bus.wb_reg;
            wr_data = bus.wb_data;
         end
         SRC_FIFO: begin
            wr_reg  = head.idx;
            wr_data = head.data;
         end
         SRC_BYPASS: begin
            wr_reg  = bus.md_done_reg;
            wr_data = bus.md_done_data;
         end
         default: ;
      endcase
   end

   assign bus.ctrl_writeEnable = (src != SRC_NONE) && (wr_reg != REG_ZERO);
   assign bus.ctrl_writeReg    = wr_reg;
   assign bus.data_writeReg    = wr_data;

   assign md_wr     = pop | bypass;
   assign md_wr_reg = pop ? head.idx : bus.md_done_reg;

   assign bus.issue_stall = bus.md_issue & busy[bus.md_issue_reg];
   assign issue_set       = bus.md_issue & ~bus.issue_stall & (bus.md_issue_reg != REG_ZERO);

   // Set is applied after clear so a same-cycle re-issue keeps the register busy.
   always_comb begin
      busy_nxt = busy;
      if (md_wr)     busy_nxt[md_wr_reg]        = 1'b0;
      if (issue_set) busy_nxt[bus.md_issue_reg] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clock) begin
      if (ctrl_reset) busy <= '0;
      else            busy <= busy_nxt;
   end

   assign bus.hazard_a = busy[bus.ctrl_readRegA];
   assign bus.hazard_b = busy[bus.ctrl_readRegB];

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed scenarios plus a randomized run checked against a queue/array model
// of the writeback arbiter.
module tb_writeback_arbiter;
   import writeback_arbiter_pkg::*;

   localparam int DEPTH = MD_FIFO_DEPTH_DEF;

   logic clock;
   logic ctrl_reset;
   int   total;
   int   bad;

   writeback_arbiter_if bus ();

   writeback_arbiter #(.MD_FIFO_DEPTH(DEPTH)) dut (
      .clock      (clock),
      .ctrl_reset (ctrl_reset),
      .bus        (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic reg_idx_t rand_reg();
      return reg_idx_t'($urandom_range(0, NUM_REGS-1));
   endfunction

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      bus.wb_valid      = 1'b0;
      bus.wb_reg        = '0;
      bus.wb_data       = '0;
      bus.md_issue      = 1'b0;
      bus.md_issue_reg  = '0;
      bus.md_done       = 1'b0;
      bus.md_done_reg   = '0;
      bus.md_done_data  = '0;
      bus.ctrl_readRegA = '0;
      bus.ctrl_readRegB = '0;
   endtask

   task automatic test_reset();
      idle();
      ctrl_reset = 1'b1;
      next_cycle();
      next_cycle();
      ctrl_reset = 1'b0;
      bus.ctrl_readRegA = 5'd7;
      bus.ctrl_readRegB = 5'd9;
      @(negedge clock);
      total++; if (bus.ctrl_writeEnable !== 1'b0) begin bad++; $display("FAIL rst_we got=%0b exp=0", bus.ctrl_writeEnable); end
      total++; if (bus.ctrl_writeReg !== 5'd0) begin bad++; $display("FAIL rst_reg got=%0d exp=0", bus.ctrl_writeReg); end
      total++; if (bus.data_writeReg !== 32'd0) begin bad++; $display("FAIL rst_data got=%h exp=0", bus.data_writeReg); end
      total++; if (bus.md_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0b exp=1", bus.md_ready); end
      total++; if (bus.hazard_a !== 1'b0 || bus.hazard_b !== 1'b0) begin bad++; $display("FAIL rst_hazard got=%0b%0b exp=00", bus.hazard_a, bus.hazard_b); end
      next_cycle();
   endtask

   task automatic test_wb_write();
      idle();
      bus.wb_valid = 1'b1; bus.wb_reg = 5'd5; bus.wb_data = 32'hDEADBEEF;
      @(negedge clock);
      total++; if (bus.ctrl_writeEnable !== 1'b1) begin bad++; $display("FAIL wb_we got=%0b exp=1", bus.ctrl_writeEnable); end
      total++; if (bus.ctrl_writeReg !== 5'd5) begin bad++; $display("FAIL wb_reg got=%0d exp=5", bus.ctrl_writeReg); end
      total++; if (bus.data_writeReg !== 32'hDEADBEEF) begin bad++; $display("FAIL wb_data got=%h exp=deadbeef", bus.data_writeReg); end
      next_cycle();
      idle();
   endtask

   task automatic test_bypass();
      idle();
      bus.md_issue = 1'b1; bus.md_issue_reg = 5'd7;
      @(negedge clock);
      total++; if (bus.issue_stall !== 1'b0) begin bad++; $display("FAIL byp_issue_stall got=%0b exp=0", bus.issue_stall); end
      next_cycle();
      bus.md_issue = 1'b0; bus.ctrl_readRegA = 5'd7;
      @(negedge clock);
      total++; if (bus.hazard_a !== 1'b1) begin bad++; $display("FAIL byp_hazard_set got=%0b exp=1", bus.hazard_a); end
      next_cycle();
      bus.md_done = 1'b1; bus.md_done_reg = 5'd7; bus.md_done_data = 32'h12;
      @(negedge clock);
      total++; if (bus.ctrl_writeEnable !== 1'b1 || bus.ctrl_writeReg !== 5'd7 || bus.data_writeReg !== 32'h12)
         begin bad++; $display("FAIL byp_write got=%0b/%0d/%h exp=1/7/12", bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.data_writeReg); end
      total++; if (bus.md_ready !== 1'b1) begin bad++; $display("FAIL byp_ready got=%0b exp=1", bus.md_ready); end
      total++; if (bus.hazard_a !== 1'b1) begin bad++; $display("FAIL byp_hazard_noforward got=%0b exp=1", bus.hazard_a); end
      next_cycle();
      bus.md_done = 1'b0;
      @(negedge clock);
      total++; if (bus.hazard_a !== 1'b0) begin bad++; $display("FAIL byp_hazard_clear got=%0b exp=0", bus.hazard_a); end
      next_cycle();
      idle();
   endtask

   task automatic test_fifo_order();
      idle();
      bus.wb_valid = 1'b1; bus.wb_reg = 5'd10; bus.wb_data = 32'hA0;
      bus.md_done = 1'b1; bus.md_done_reg = 5'd3; bus.md_done_data = 32'h33;
      @(negedge clock);
      total++; if (bus.md_ready !== 1'b1 || bus.ctrl_writeReg !== 5'd10) begin bad++; $display("FAIL fifo_c1 got=ready%0b reg%0d exp=ready1 reg10", bus.md_ready, bus.ctrl_writeReg); end
      next_cycle();
      bus.wb_reg = 5'd11; bus.md_done_reg = 5'd4; bus.md_done_data = 32'h44;
      @(negedge clock);
      total++; if (bus.md_ready !== 1'b1) begin bad++; $display("FAIL fifo_c2_ready got=%0b exp=1", bus.md_ready); end
      next_cycle();
      bus.wb_reg = 5'd12; bus.md_done_reg = 5'd5; bus.md_done_data = 32'h55;
      @(negedge clock);
      total++; if (bus.md_ready !== 1'b0) begin bad++; $display("FAIL fifo_full_ready got=%0b exp=0", bus.md_ready); end
      next_cycle();
      bus.wb_valid = 1'b0;
      @(negedge clock);
      total++; if (bus.ctrl_writeEnable !== 1'b1 || bus.ctrl_writeReg !== 5'd3 || bus.data_writeReg !== 32'h33)
         begin bad++; $display("FAIL fifo_pop1 got=%0b/%0d/%h exp=1/3/33", bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.data_writeReg); end
      total++; if (bus.md_ready !== 1'b0) begin bad++; $display("FAIL fifo_pop1_ready got=%0b exp=0", bus.md_ready); end
      next_cycle();
      @(negedge clock);
      total++; if (bus.ctrl_writeReg !== 5'd4 || bus.data_writeReg !== 32'h44) begin bad++; $display("FAIL fifo_pop2 got=%0d/%h exp=4/44", bus.ctrl_writeReg, bus.data_writeReg); end
      total++; if (bus.md_ready !== 1'b1) begin bad++; $display("FAIL fifo_pop2_ready got=%0b exp=1", bus.md_ready); end
      next_cycle();
      bus.md_done = 1'b0;
      @(negedge clock);
      total++; if (bus.ctrl_writeReg !== 5'd5 || bus.data_writeReg !== 32'h55) begin bad++; $display("FAIL fifo_pop3 got=%0d/%h exp=5/55", bus.ctrl_writeReg, bus.data_writeReg); end
      next_cycle();
      @(negedge clock);
      total++; if (bus.ctrl_writeEnable !== 1'b0) begin bad++; $display("FAIL fifo_drained_we got=%0b exp=0", bus.ctrl_writeEnable); end
      next_cycle();
   endtask

   task automatic test_reg_zero();
      idle();
      bus.wb_valid = 1'b1; bus.wb_reg = 5'd0; bus.wb_data = 32'hAAAA;
      @(negedge clock);
      total++; if (bus.ctrl_writeEnable !== 1'b0) begin bad++; $display("FAIL r0_wb_we got=%0b exp=0", bus.ctrl_writeEnable); end
      next_cycle();
      bus.wb_valid = 1'b0; bus.md_done = 1'b1; bus.md_done_reg = 5'd0; bus.md_done_data = 32'hBBBB;
      @(negedge clock);
      total++; if (bus.ctrl_writeEnable !== 1'b0 || bus.md_ready !== 1'b1) begin bad++; $display("FAIL r0_md got=we%0b ready%0b exp=we0 ready1", bus.ctrl_writeEnable, bus.md_ready); end
      next_cycle();
      bus.md_done = 1'b0;
      @(negedge clock);
      total++; if (bus.data_writeReg !== 32'd0) begin bad++; $display("FAIL r0_consumed got=%h exp=0", bus.data_writeReg); end
      next_cycle();
   endtask

   task automatic test_waw_stall();
      idle();
      bus.md_issue = 1'b1; bus.md_issue_reg = 5'd9;
      @(negedge clock);
      total++; if (bus.issue_stall !== 1'b0) begin bad++; $display("FAIL waw_first got=%0b exp=0", bus.issue_stall); end
      next_cycle();
      @(negedge clock);
      total++; if (bus.issue_stall !== 1'b1) begin bad++; $display("FAIL waw_second got=%0b exp=1", bus.issue_stall); end
      next_cycle();
      bus.md_issue = 1'b0; bus.ctrl_readRegB = 5'd9;
      bus.md_done = 1'b1; bus.md_done_reg = 5'd9; bus.md_done_data = 32'h99;
      @(negedge clock);
      total++; if (bus.hazard_b !== 1'b1 || bus.ctrl_writeReg !== 5'd9) begin bad++; $display("FAIL waw_bypass got=hz%0b reg%0d exp=hz1 reg9", bus.hazard_b, bus.ctrl_writeReg); end
      next_cycle();
      bus.wb_valid = 1'b1; bus.wb_reg = 5'd20; bus.wb_data = 32'h20;
      bus.md_done_data = 32'h55;
      @(negedge clock);
      total++; if (bus.hazard_b !== 1'b0) begin bad++; $display("FAIL waw_cleared got=%0b exp=0", bus.hazard_b); end
      next_cycle();
      // buffered reg-9 result pops while reg 9 is re-issued
      bus.wb_valid = 1'b0; bus.md_done = 1'b0; bus.md_issue = 1'b1; bus.md_issue_reg = 5'd9;
      @(negedge clock);
      total++; if (bus.ctrl_writeReg !== 5'd9 || bus.data_writeReg !== 32'h55 || bus.issue_stall !== 1'b0)
         begin bad++; $display("FAIL waw_pop_issue got=%0d/%h/stall%0b exp=9/55/stall0", bus.ctrl_writeReg, bus.data_writeReg, bus.issue_stall); end
      next_cycle();
      @(negedge clock);
      total++; if (bus.hazard_b !== 1'b1 || bus.issue_stall !== 1'b1) begin bad++; $display("FAIL waw_set_wins got=hz%0b stall%0b exp=hz1 stall1", bus.hazard_b, bus.issue_stall); end
      next_cycle();
      bus.md_issue = 1'b0; bus.md_done = 1'b1; bus.md_done_reg = 5'd9;
      next_cycle();
      idle();
   endtask

   task automatic test_mid_reset();
      idle();
      bus.md_issue = 1'b1; bus.md_issue_reg = 5'd13;
      next_cycle();
      bus.md_issue = 1'b0;
      bus.wb_valid = 1'b1; bus.wb_reg = 5'd14; bus.md_done = 1'b1; bus.md_done_reg = 5'd15; bus.md_done_data = 32'h15;
      next_cycle();
      bus.wb_reg = 5'd16; bus.md_done_reg = 5'd17; bus.md_done_data = 32'h17;
      next_cycle();
      idle();
      ctrl_reset = 1'b1;
      next_cycle();
      ctrl_reset = 1'b0; bus.ctrl_readRegA = 5'd13;
      @(negedge clock);
      total++; if (bus.ctrl_writeEnable !== 1'b0 || bus.ctrl_writeReg !== 5'd0) begin bad++; $display("FAIL mrst_we got=%0b/%0d exp=0/0", bus.ctrl_writeEnable, bus.ctrl_writeReg); end
      total++; if (bus.md_ready !== 1'b1) begin bad++; $display("FAIL mrst_ready got=%0b exp=1", bus.md_ready); end
      total++; if (bus.hazard_a !== 1'b0) begin bad++; $display("FAIL mrst_busy got=%0b exp=0", bus.hazard_a); end
      next_cycle();
   endtask

   task automatic test_random();
      logic     mbusy [NUM_REGS];
      reg_idx_t q_reg [$];
      data_t    q_data [$];
      logic     pend;
      logic     e_ready, e_any, e_we, e_stall, from_q, byp;
      reg_idx_t e_reg, r;
      data_t    e_data;
      foreach (mbusy[i]) mbusy[i] = 1'b0;
      pend = 1'b0;
      idle();
      ctrl_reset = 1'b1;
      next_cycle();
      ctrl_reset = 1'b0;
      for (int c = 0; c < 600; c++) begin
         bus.wb_valid = ($urandom_range(0, 99) < 45);
         r = rand_reg();
         for (int t = 0; t < 8 && mbusy[r]; t++) r = rand_reg();
         if (mbusy[r]) r = '0;
         bus.wb_reg  = r;
         bus.wb_data = $urandom;
         if (!pend) begin
            pend = ($urandom_range(0, 99) < 40);
            bus.md_done_reg  = rand_reg();
            bus.md_done_data = $urandom;
         end
         bus.md_done       = pend;
         bus.md_issue      = ($urandom_range(0, 99) < 30);
         bus.md_issue_reg  = rand_reg();
         bus.ctrl_readRegA = rand_reg();
         bus.ctrl_readRegB = rand_reg();

         e_ready = (q_reg.size() < DEPTH) || (!bus.wb_valid && q_reg.size() == 0);
         from_q = 1'b0; byp = 1'b0; e_any = 1'b1;
         if (bus.wb_valid) begin e_reg = bus.wb_reg; e_data = bus.wb_data; end
         else if (q_reg.size() != 0) begin e_reg = q_reg[0]; e_data = q_data[0]; from_q = 1'b1; end
         else if (bus.md_done) begin e_reg = bus.md_done_reg; e_data = bus.md_done_data; byp = 1'b1; end
         else begin e_reg = '0; e_data = '0; e_any = 1'b0; end
         e_we    = e_any && (e_reg != 0);
         e_stall = bus.md_issue && mbusy[bus.md_issue_reg];

         @(negedge clock);
         total++; if (bus.ctrl_writeEnable !== e_we) begin bad++; $display("FAIL rnd_we c=%0d got=%0b exp=%0b", c, bus.ctrl_writeEnable, e_we); end
         total++; if (bus.ctrl_writeReg !== e_reg) begin bad++; $display("FAIL rnd_reg c=%0d got=%0d exp=%0d", c, bus.ctrl_writeReg, e_reg); end
         total++; if (bus.data_writeReg !== e_data) begin bad++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, bus.data_writeReg, e_data); end
         total++; if (bus.md_ready !== e_ready) begin bad++; $display("FAIL rnd_ready c=%0d got=%0b exp=%0b", c, bus.md_ready, e_ready); end
         total++; if (bus.issue_stall !== e_stall) begin bad++; $display("FAIL rnd_stall c=%0d got=%0b exp=%0b", c, bus.issue_stall, e_stall); end
         total++; if (bus.hazard_a !== mbusy[bus.ctrl_readRegA] || bus.hazard_b !== mbusy[bus.ctrl_readRegB])
            begin bad++; $display("FAIL rnd_hazard c=%0d got=%0b%0b exp=%0b%0b", c, bus.hazard_a, bus.hazard_b, mbusy[bus.ctrl_readRegA], mbusy[bus.ctrl_readRegB]); end

         if (from_q) begin
            mbusy[q_reg[0]] = 1'b0;
            void'(q_reg.pop_front());
            void'(q_data.pop_front());
         end
         if (byp) mbusy[bus.md_done_reg] = 1'b0;
         if (bus.md_done && e_ready && !byp) begin
            q_reg.push_back(bus.md_done_reg);
            q_data.push_back(bus.md_done_data);
         end
         if (bus.md_issue && !e_stall && bus.md_issue_reg != 0) mbusy[bus.md_issue_reg] = 1'b1;
         mbusy[0] = 1'b0;
         if (bus.md_done && e_ready) pend = 1'b0;
         next_cycle();
      end
      idle();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      ctrl_reset = 1'b1;
      idle();
      test_reset();
      test_wb_write();
      test_bypass();
      test_fifo_order();
      test_reg_zero();
      test_waw_stall();
      test_mid_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
